// File: rtl/triangle_deserializer.sv
// rtl/triangle_deserializer.sv - byte stream to triangle_t unpacker with a valid/ready output stage
// Bytes arrive MSB-first over the packed triangle; a framing error drops the partial frame.
module triangle_deserializer #(
    parameter int FIXED_W       = 16,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int TRI_BITS      = 9 * FIXED_W + 36,
    parameter int NBYTES        = (TRI_BITS + 7) / 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRI_BITS-1:0]      out_triangle,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int ASM_BITS = 8 * NBYTES;
    localparam int CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PENDING = 2'd1,
        RESYNC  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ASM_BITS-1:0]        asm_q, asm_d;
    logic [TRI_BITS-1:0]        out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       err_pulse_q, err_pulse_d;
    logic [ERR_CNT_WIDTH-1:0]   err_count_q, err_count_d;
    logic                       run_q, run_d;

    logic accept;
    logic out_hs;
    logic out_free;
    logic frame_err;

    // run_q keeps in_ready low during reset and releases it one edge later
    assign in_ready     = run_q && (state_q != PENDING);
    assign accept       = in_valid && in_ready;
    assign out_hs       = out_valid_q && out_ready;
    assign out_free     = !out_valid_q || out_ready;
    assign out_valid    = out_valid_q;
    assign out_triangle = out_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        run_d       = 1'b1;
        frame_err   = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            asm_d[8*(NBYTES-k)-1 -: 8] = in_data;
                        end
                    end
                    if (in_last && cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (out_free) begin
                            out_d       = asm_d[TRI_BITS-1:0];
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = PENDING;
                        end
                    end else if (in_last) begin
                        cnt_d     = '0;
                        frame_err = 1'b1;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d     = '0;
                        frame_err = 1'b1;
                        state_d   = RESYNC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (out_hs) begin
                    out_d       = asm_q[TRI_BITS-1:0];
                    out_valid_d = 1'b1;
                    state_d     = COLLECT;
                end
            end
            RESYNC: begin
                if (accept && in_last) begin
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase

        if (frame_err) begin
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            run_q       <= run_d;
        end
    end

endmodule

// File: tb/tb_triangle_deserializer.sv
// tb/tb_triangle_deserializer.sv - scoreboard bench for triangle_deserializer (W=16, 23-byte frames)
module tb_triangle_deserializer;

    localparam int TRI_BITS = 180;
    localparam int NBYTES   = 23;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          in_data = 8'h00;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [TRI_BITS-1:0] out_triangle;
    logic                err_pulse;
    logic [7:0]          err_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [TRI_BITS-1:0] exp_q[$];

    triangle_deserializer dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_triangle (out_triangle),
        .err_pulse    (err_pulse),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [TRI_BITS-1:0] act, input logic [TRI_BITS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: samples 2ns after the falling edge, once drivers have settled
    logic                prev_hold = 1'b0;
    logic [TRI_BITS-1:0] prev_tri = '0;
    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (err_pulse) pulses++;
            if (prev_hold) begin
                check("hold_valid", TRI_BITS'(out_valid), TRI_BITS'(1));
                check("hold_data", out_triangle, prev_tri);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_triangle);
                end else begin
                    check("triangle", out_triangle, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_tri  = out_triangle;
        end
    end

    // Builds the expected triangle by shifting bytes in, then dropping the 4 pad bits
    function automatic logic [TRI_BITS-1:0] frame_value(input logic [7:0] seed);
        logic [8*NBYTES-1:0] full;
        full = '0;
        for (int k = 0; k < NBYTES; k++) full = (full << 8) | (8*NBYTES)'(8'(seed + 8'(k)));
        return full[TRI_BITS-1:0];
    endfunction

    // Called on a falling edge; returns on the falling edge after acceptance
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic rdy;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            #1 rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            guard++;
            if (guard > 2000) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seed, input bit expect_out);
        for (int k = 0; k < NBYTES; k++) send_byte(8'(seed + 8'(k)), k == NBYTES - 1);
        if (expect_out) exp_q.push_back(frame_value(seed));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", TRI_BITS'(exp_q.size()), TRI_BITS'(0));
    endtask

    int exp_err;

    initial begin
        exp_err = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", TRI_BITS'(in_ready), TRI_BITS'(0));
        check("rst_out_valid", TRI_BITS'(out_valid), TRI_BITS'(0));
        check("rst_out_tri", out_triangle, '0);
        check("rst_err_count", TRI_BITS'(err_count), TRI_BITS'(0));
        check("rst_err_pulse", TRI_BITS'(err_pulse), TRI_BITS'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", TRI_BITS'(in_ready), TRI_BITS'(1));

        // 1: single frame, latency one cycle from the last byte
        out_ready = 1'b1;
        for (int k = 0; k < NBYTES - 1; k++) send_byte(8'(k), 1'b0);
        check("t1_not_valid_early", TRI_BITS'(out_valid), TRI_BITS'(0));
        exp_q.push_back(frame_value(8'h00));
        send_byte(8'h16, 1'b1);
        check("t1_valid_latency", TRI_BITS'(out_valid), TRI_BITS'(1));
        check("t1_triangle_const", out_triangle, {4'h0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10, 8'h11, 8'h12,
              8'h13, 8'h14, 8'h15, 8'h16});
        drain();
        check("t1_err_count", TRI_BITS'(err_count), TRI_BITS'(0));

        // 2: back-to-back frames with consumer stalled
        out_ready = 1'b0;
        send_frame(8'h40, 1'b1);
        send_frame(8'h80, 1'b1);
        #1;
        check("t2_pending_in_ready", TRI_BITS'(in_ready), TRI_BITS'(0));
        check("t2_out_valid", TRI_BITS'(out_valid), TRI_BITS'(1));
        @(negedge clk);
        drain();

        // 3: early in_last
        for (int k = 0; k < 6; k++) send_byte(8'(8'hA0 + 8'(k)), k == 5);
        exp_err++;
        @(negedge clk);
        check("t3_err_count", TRI_BITS'(err_count), TRI_BITS'(exp_err));
        check("t3_pulses", TRI_BITS'(pulses), TRI_BITS'(exp_err));
        send_frame(8'hC3, 1'b1);
        drain();

        // 4: missing in_last, resync through three more bytes
        for (int k = 0; k < NBYTES; k++) send_byte(8'(8'h10 + 8'(k)), 1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'(8'hE0 + 8'(k)), k == 2);
        exp_err++;
        @(negedge clk);
        check("t4_err_count", TRI_BITS'(err_count), TRI_BITS'(exp_err));
        check("t4_pulses", TRI_BITS'(pulses), TRI_BITS'(exp_err));
        send_frame(8'h5A, 1'b1);
        drain();

        // 5: reset mid-frame while a triangle is held
        out_ready = 1'b0;
        send_frame(8'h31, 1'b1);
        for (int k = 0; k < 10; k++) send_byte(8'(k), 1'b0);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("t5_out_valid_rst", TRI_BITS'(out_valid), TRI_BITS'(0));
        check("t5_in_ready_rst", TRI_BITS'(in_ready), TRI_BITS'(0));
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        exp_err = 0;
        @(negedge clk);
        out_ready = 1'b1;
        send_frame(8'h77, 1'b1);
        drain();
        check("t5_err_count", TRI_BITS'(err_count), TRI_BITS'(0));

        // 6: saturate the error counter with single-byte frames
        for (int i = 0; i < 259; i++) send_byte(8'(i), 1'b1);
        @(negedge clk);
        check("t6_err_sat", TRI_BITS'(err_count), TRI_BITS'(8'hFF));
        check("t6_pulses", TRI_BITS'(pulses), TRI_BITS'(259));
        send_frame(8'h01, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
